// File: rtl/trng_pkg.sv
// Shared definitions for the ring-oscillator TRNG sequencer: FSM state encodings
// and the counter width helper.
package trng_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WARMUP = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_OUTPUT = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    // Bits needed for a counter holding values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs consecutive sample bits and emits the first bit of
// any pair whose two bits differ.
module trng_vn_debias (
    input  logic clk,
    input  logic rst,
    input  logic sample_stb,
    input  logic sample_bit,
    input  logic clear,
    output logic bit_valid,
    output logic bit_val
);

    logic have_a_q;
    logic a_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            have_a_q <= 1'b0;
            a_q      <= 1'b0;
        end else if (sample_stb) begin
            have_a_q <= !have_a_q;
            if (!have_a_q) begin
                a_q <= sample_bit;
            end
        end
    end

    assign bit_valid = sample_stb && have_a_q && (a_q != sample_bit);
    assign bit_val   = a_q;

endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: oscillator enable and warm-up, divided sampling, debiasing,
// byte packing with valid/ready output, and a repetition-count health test.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV    = 16,
    parameter int unsigned WARMUP_CYCLES = 256,
    parameter int unsigned RCT_LIMIT     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       osc_en,
    input  logic       osc_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic       fault
);

    localparam int unsigned WW = cnt_width(WARMUP_CYCLES);
    localparam int unsigned SW = cnt_width(SAMPLE_DIV);
    localparam int unsigned RW = cnt_width(RCT_LIMIT + 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(RCT_LIMIT);

    logic          osc_meta_q, osc_sync_q;
    logic [2:0]    state_q, state_d;
    logic [WW-1:0] warm_q, warm_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [RW-1:0] run_q, run_d, run_next;
    logic          prev_q, prev_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shreg_q, shreg_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;

    logic       sample_stb;
    logic       deb_valid, deb_bit;
    logic       rct_hit, byte_done;
    logic [7:0] shift_in;

    assign sample_stb = (state_q == ST_SAMPLE) && (samp_q == SAMP_LAST);

    trng_vn_debias u_debias (
        .clk        (clk),
        .rst        (rst),
        .sample_stb (sample_stb),
        .sample_bit (osc_sync_q),
        .clear      (state_q != ST_SAMPLE),
        .bit_valid  (deb_valid),
        .bit_val    (deb_bit)
    );

    // run_q == 0 means no previous sample since entering SAMPLE.
    assign run_next  = (run_q != '0 && osc_sync_q == prev_q) ? run_q + RW'(1) : RW'(1);
    assign rct_hit   = sample_stb && (run_next == RUN_LIMIT);
    assign shift_in  = {shreg_q, deb_bit};
    assign byte_done = deb_valid && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        warm_d    = '0;
        samp_d    = '0;
        run_d     = run_q;
        prev_d    = prev_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_WARMUP;
            end
            ST_WARMUP: begin
                warm_d = warm_q + WW'(1);
                if (!en) state_d = ST_IDLE;
                else if (warm_q == WARM_LAST) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                samp_d = sample_stb ? '0 : samp_q + SW'(1);
                if (sample_stb) begin
                    run_d  = run_next;
                    prev_d = osc_sync_q;
                end
                if (deb_valid) begin
                    shreg_d   = shift_in[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                // Health-test failure beats byte completion, which beats en falling.
                if (rct_hit) begin
                    state_d = ST_FAULT;
                end else if (byte_done) begin
                    state_d = ST_OUTPUT;
                    byte_d  = shift_in;
                    valid_d = 1'b1;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUTPUT: begin
                if (valid_q && byte_ready) begin
                    valid_d = 1'b0;
                    state_d = en ? ST_SAMPLE : ST_IDLE;
                end
            end
            ST_FAULT: ;
            default: state_d = ST_IDLE;
        endcase
        if (state_d != ST_SAMPLE) begin
            run_d     = '0;
            bit_cnt_d = '0;
            shreg_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            osc_meta_q <= 1'b0;
            osc_sync_q <= 1'b0;
            state_q    <= ST_IDLE;
            warm_q     <= '0;
            samp_q     <= '0;
            run_q      <= '0;
            prev_q     <= 1'b0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            osc_meta_q <= osc_in;
            osc_sync_q <= osc_meta_q;
            state_q    <= state_d;
            warm_q     <= warm_d;
            samp_q     <= samp_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
        end
    end

    assign osc_en     = (state_q == ST_WARMUP) || (state_q == ST_SAMPLE) ||
                        (state_q == ST_OUTPUT);
    assign busy       = osc_en;
    assign fault      = (state_q == ST_FAULT);
    assign byte_data  = byte_q;
    assign byte_valid = valid_q;

endmodule
